// File: rtl/dds_wave_gen_if.sv
// dds_wave_gen_if
//   Control/sample bundle between the register block (master) and the
//   DDS waveform generator (slave).
//   master drives : enable, phase_clr, freq_we, freq_in, phase_off, mode
//   slave drives  : wave_out, sample_valid, cycle_wrap, freq_pending
interface dds_wave_gen_if #(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 24
);
   logic               enable;
   logic               phase_clr;
   logic               freq_we;
   logic [PHASE_W-1:0] freq_in;
   logic [PHASE_W-1:0] phase_off;
   logic [1:0]         mode;
   logic [DATA_W-1:0]  wave_out;
   logic               sample_valid;
   logic               cycle_wrap;
   logic               freq_pending;

   modport master (
      output enable, phase_clr, freq_we, freq_in, phase_off, mode,
      input  wave_out, sample_valid, cycle_wrap, freq_pending
   );

   modport slave (
      input  enable, phase_clr, freq_we, freq_in, phase_off, mode,
      output wave_out, sample_valid, cycle_wrap, freq_pending
   );
endinterface

// File: rtl/dds_wave_gen.sv
// dds_wave_gen
//   Direct-digital-synthesis waveform generator. A phase accumulator feeds a
//   four-stage pipeline producing sine (quarter-wave LUT), triangle,
//   sawtooth or square samples. Frequency words written while running are
//   held in a shadow register and take effect at the next phase wrap.
//   Ports:
//     clk_in : single rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : dds_wave_gen_if.slave (controls in, samples and status out)
module dds_wave_gen #(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 24,
   parameter int LUT_AW  = 8
) (
   input  logic          clk_in,
   input  logic          rst_n,
   dds_wave_gen_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_SINE   = 2'd0,
      MODE_TRI    = 2'd1,
      MODE_SAW    = 2'd2,
      MODE_SQUARE = 2'd3
   } mode_e;

   localparam int LUT_N = 2 ** LUT_AW;

   // Quarter-wave sample i, taken at the middle of its bin so the mirrored
   // quadrants meet symmetrically. Evaluated only at elaboration.
   function automatic logic [DATA_W-2:0] lut_entry(input int idx);
      real x, term, s;
      x    = 1.5707963267948966 * (real'(idx) + 0.5) / real'(LUT_N);
      term = x;
      s    = x;
      for (int k = 1; k < 10; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      return (DATA_W-1)'($rtoi(s * real'((2 ** (DATA_W - 1)) - 1) + 0.5));
   endfunction

   // NOTE: the LUT is a constant table with no write port, so it carries no
   // reset; it folds into ROM/logic.
   logic [DATA_W-2:0] lut [LUT_N];
   for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      assign lut[gi] = lut_entry(gi);
   end

   // ---------------- accumulator and frequency control ----------------
   logic [PHASE_W-1:0] acc, fword, shadow;
   logic               pending;
   logic               wrap_pend;   // a carry happened; flag the next sample
   logic [PHASE_W:0]   acc_sum;
   logic               carry;

   assign acc_sum = {1'b0, acc} + {1'b0, fword};
   assign carry   = acc_sum[PHASE_W];

   logic               s1_valid, s1_wrap;
   logic [PHASE_W-1:0] s1_p;
   mode_e              s1_mode;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         fword     <= '0;
         shadow    <= '0;
         pending   <= 1'b0;
         wrap_pend <= 1'b0;
         s1_valid  <= 1'b0;
         s1_wrap   <= 1'b0;
         s1_p      <= '0;
         s1_mode   <= MODE_SINE;
      end else begin
         s1_valid <= 1'b0;
         if (bus.phase_clr) begin
            acc       <= '0;
            wrap_pend <= 1'b0;
            pending   <= 1'b0;
            if (bus.freq_we)  fword <= bus.freq_in;
            else if (pending) fword <= shadow;
         end else if (bus.enable) begin
            acc       <= acc_sum[PHASE_W-1:0];
            wrap_pend <= carry;
            s1_valid  <= 1'b1;
            s1_wrap   <= wrap_pend;
            s1_p      <= acc + bus.phase_off;   // offset never feeds back
            s1_mode   <= mode_e'(bus.mode);
            if (carry) begin
               // a write on the wrap edge itself wins over the shadow
               if (bus.freq_we)  fword <= bus.freq_in;
               else if (pending) fword <= shadow;
               pending <= 1'b0;
            end else if (bus.freq_we) begin
               shadow  <= bus.freq_in;
               pending <= 1'b1;
            end
         end else if (bus.freq_we) begin
            fword   <= bus.freq_in;
            pending <= 1'b0;
         end
      end
   end

   // ---------------- stage 2 decode ----------------
   logic [1:0]        qd;
   logic [LUT_AW-1:0] addr_raw, addr;
   logic [DATA_W:0]   tri_t;
   logic [DATA_W-1:0] alt;

   always_comb begin
      qd       = s1_p[PHASE_W-1 -: 2];
      addr_raw = s1_p[PHASE_W-3 -: LUT_AW];
      addr     = qd[0] ? ~addr_raw : addr_raw;   // odd quadrants run backwards
      tri_t    = s1_p[PHASE_W-1 -: DATA_W+1];
      // NOTE: default first so every path assigns alt and no latch is inferred.
      alt      = '0;
      case (s1_mode)
         MODE_TRI:    alt = tri_t[DATA_W] ? ~tri_t[DATA_W-1:0] : tri_t[DATA_W-1:0];
         MODE_SAW:    alt = s1_p[PHASE_W-1 -: DATA_W];
         MODE_SQUARE: alt = s1_p[PHASE_W-1] ? '0 : '1;
         default:     alt = '0;
      endcase
   end

   // Low phase bits only matter through the decode above.
   logic unused_phase_bits;
   assign unused_phase_bits = ^s1_p;

   // ---------------- stages 2..4 ----------------
   logic              s2_valid, s2_wrap, s2_neg;
   logic [LUT_AW-1:0] s2_addr;
   mode_e             s2_mode;
   logic [DATA_W-1:0] s2_alt;
   logic              s3_valid, s3_wrap, s3_neg;
   logic [DATA_W-2:0] s3_q;
   mode_e             s3_mode;
   logic [DATA_W-1:0] s3_alt;
   logic [DATA_W-1:0] wave_q;
   logic              valid_q, wrap_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_wrap  <= 1'b0;
         s2_neg   <= 1'b0;
         s2_addr  <= '0;
         s2_mode  <= MODE_SINE;
         s2_alt   <= '0;
         s3_valid <= 1'b0;
         s3_wrap  <= 1'b0;
         s3_neg   <= 1'b0;
         s3_q     <= '0;
         s3_mode  <= MODE_SINE;
         s3_alt   <= '0;
         wave_q   <= {1'b1, {(DATA_W-1){1'b0}}};
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         s2_wrap  <= s1_wrap;
         s2_neg   <= qd[1];
         s2_addr  <= addr;
         s2_mode  <= s1_mode;
         s2_alt   <= alt;

         s3_valid <= s2_valid;
         s3_wrap  <= s2_wrap;
         s3_neg   <= s2_neg;
         s3_q     <= lut[s2_addr];
         s3_mode  <= s2_mode;
         s3_alt   <= s2_alt;

         valid_q  <= s3_valid;
         wrap_q   <= s3_valid & s3_wrap;
         if (s3_valid) begin
            // {1,q} = mid + q ; {0,~q} = mid - 1 - q
            if (s3_mode == MODE_SINE) wave_q <= s3_neg ? {1'b0, ~s3_q} : {1'b1, s3_q};
            else                      wave_q <= s3_alt;
         end
      end
   end

   assign bus.wave_out     = wave_q;
   assign bus.sample_valid = valid_q;
   assign bus.cycle_wrap   = wrap_q;
   assign bus.freq_pending = pending;

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen
//   Directed bench for dds_wave_gen at default widths. A vector table of
//   {mode, sample index, expected value} is checked against captured
//   sample streams, followed by hand-written multi-cycle sequences.
module tb_dds_wave_gen;
   localparam int DATA_W  = 8;
   localparam int PHASE_W = 24;
   localparam int LUT_AW  = 8;

   localparam logic [PHASE_W-1:0] F16   = 24'h010000;
   localparam logic [PHASE_W-1:0] F17   = 24'h020000;
   localparam logic [PHASE_W-1:0] F18   = 24'h040000;
   localparam logic [PHASE_W-1:0] OFF90 = 24'h400000;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_in = ~clk_in;

   dds_wave_gen_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus ();

   dds_wave_gen #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   typedef struct {
      int mode;
      int idx;
      int exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cap      = 0;
   int   samp_q[$];
   int   wrap_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: count captures at the rising edge, record any valid sample
   // at the falling edge.
   task automatic tick();
      @(posedge clk_in);
      if (rst_n && bus.enable && !bus.phase_clr) cap++;
      @(negedge clk_in);
      if (bus.sample_valid) begin
         samp_q.push_back(int'(bus.wave_out));
         wrap_q.push_back(int'(bus.cycle_wrap));
      end
   endtask

   task automatic run_until_cap(input int target);
      int guard = 0;
      while (cap < target && guard < 2000) begin
         tick();
         guard++;
      end
      check("cap_reached", cap, target);
   endtask

   task automatic collect(input int n);
      int guard = 0;
      while (samp_q.size() < n && guard < n + 40) begin
         tick();
         guard++;
      end
      check("collect_count", int'(samp_q.size() >= n), 1);
   endtask

   function automatic int qget(input int i);
      return (i < samp_q.size()) ? samp_q[i] : -1;
   endfunction

   function automatic int wget(input int i);
      return (i < wrap_q.size()) ? wrap_q[i] : -1;
   endfunction

   // Stop, drain, load a word directly, clear the phase, then restart.
   task automatic restart(input int m, input logic [PHASE_W-1:0] off,
                          input logic [PHASE_W-1:0] fw);
      bus.enable = 1'b0;
      repeat (5) tick();
      bus.freq_we = 1'b1;
      bus.freq_in = fw;
      tick();
      bus.freq_we   = 1'b0;
      bus.phase_clr = 1'b1;
      tick();
      bus.phase_clr = 1'b0;
      samp_q.delete();
      wrap_q.delete();
      cap           = 0;
      bus.mode      = 2'(m);
      bus.phase_off = off;
      bus.enable    = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nz, nw, pend_seen, last;

      // sine
      vecs.push_back(vec_t'{0, 0, 128});
      vecs.push_back(vec_t'{0, 32, 218});
      vecs.push_back(vec_t'{0, 63, 255});
      vecs.push_back(vec_t'{0, 64, 255});
      vecs.push_back(vec_t'{0, 128, 127});
      vecs.push_back(vec_t'{0, 191, 0});
      vecs.push_back(vec_t'{0, 192, 0});
      vecs.push_back(vec_t'{0, 256, 128});
      // triangle
      vecs.push_back(vec_t'{1, 0, 0});
      vecs.push_back(vec_t'{1, 1, 2});
      vecs.push_back(vec_t'{1, 127, 254});
      vecs.push_back(vec_t'{1, 128, 255});
      vecs.push_back(vec_t'{1, 129, 253});
      vecs.push_back(vec_t'{1, 255, 1});
      // sawtooth
      vecs.push_back(vec_t'{2, 0, 0});
      vecs.push_back(vec_t'{2, 1, 1});
      vecs.push_back(vec_t'{2, 200, 200});
      vecs.push_back(vec_t'{2, 255, 255});
      // square
      vecs.push_back(vec_t'{3, 0, 255});
      vecs.push_back(vec_t'{3, 127, 255});
      vecs.push_back(vec_t'{3, 128, 0});
      vecs.push_back(vec_t'{3, 255, 0});

      bus.enable    = 1'b0;
      bus.phase_clr = 1'b0;
      bus.freq_we   = 1'b0;
      bus.freq_in   = '0;
      bus.phase_off = '0;
      bus.mode      = 2'd0;

      // ---- reset state ----
      #12;
      check("rst_wave_out", int'(bus.wave_out), 128);
      check("rst_sample_valid", int'(bus.sample_valid), 0);
      check("rst_cycle_wrap", int'(bus.cycle_wrap), 0);
      check("rst_freq_pending", int'(bus.freq_pending), 0);
      @(negedge clk_in);
      rst_n = 1'b1;

      // ---- idle write, then latency of the first sine sample ----
      bus.freq_we = 1'b1;
      bus.freq_in = F16;
      tick();
      bus.freq_we = 1'b0;
      check("idle_write_no_pending", int'(bus.freq_pending), 0);
      bus.enable = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.sample_valid && lat < 10);
      check("latency_edges_after_capture", lat - 1, 3);
      check("first_sine_sample", qget(0), 128);
      collect(520);

      // ---- table vectors, one captured stream per mode ----
      for (int m = 0; m < 4; m++) begin
         if (m != 0) begin
            restart(m, '0, F16);
            collect(260);
         end else begin
            check("sine_wrap_at_256", wget(256), 1);
            nw = 0;
            for (int i = 0; i < 512; i++) if (wget(i) == 1) nw++;
            check("sine_wraps_in_512", nw, 1);
         end
         foreach (vecs[v]) begin
            if (vecs[v].mode == m)
               check($sformatf("vec_m%0d_s%0d", m, vecs[v].idx), qget(vecs[v].idx), vecs[v].exp);
         end
      end

      // ---- drain and hold after enable falls ----
      restart(2, '0, F16);
      collect(40);
      bus.enable = 1'b0;
      last = (cap - 1) % 256;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (bus.sample_valid && lat < 10);
      check("valid_drop_edges", lat, 4);
      repeat (3) tick();
      check("wave_out_hold", int'(bus.wave_out), last);

      // ---- phase offset: cosine start ----
      restart(0, OFF90, F16);
      collect(4);
      check("offset_first_sample", qget(0), 255);

      // ---- deferred frequency change ----
      restart(2, '0, F16);
      run_until_cap(10);
      bus.freq_we = 1'b1;
      bus.freq_in = F17;
      tick();
      bus.freq_we = 1'b0;
      check("deferred_pending_set", int'(bus.freq_pending), 1);
      run_until_cap(255);
      check("deferred_pending_hold", int'(bus.freq_pending), 1);
      tick();
      check("deferred_pending_clear", int'(bus.freq_pending), 0);
      collect(390);
      check("deferred_s255", qget(255), 255);
      check("deferred_s256", qget(256), 0);
      check("deferred_s257", qget(257), 2);
      check("deferred_s383", qget(383), 254);
      check("deferred_s384", qget(384), 0);
      check("deferred_wrap_256", wget(256), 1);
      check("deferred_wrap_383", wget(383), 0);
      check("deferred_wrap_384", wget(384), 1);

      // ---- write on the wrap edge ----
      restart(2, '0, F16);
      run_until_cap(255);
      bus.freq_we = 1'b1;
      bus.freq_in = F18;
      pend_seen = 0;
      tick();
      bus.freq_we = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.freq_pending) pend_seen = 1;
         tick();
      end
      check("wrapedge_no_pending", pend_seen, 0);
      collect(270);
      check("wrapedge_s256", qget(256), 0);
      check("wrapedge_s257", qget(257), 4);
      check("wrapedge_s258", qget(258), 8);

      // ---- phase_clr mid-cycle applies the pending word ----
      restart(2, '0, F16);
      run_until_cap(20);
      bus.freq_we = 1'b1;
      bus.freq_in = F17;
      tick();
      bus.freq_we = 1'b0;
      check("clr_pending_before", int'(bus.freq_pending), 1);
      run_until_cap(50);
      bus.phase_clr = 1'b1;
      tick();
      bus.phase_clr = 1'b0;
      check("clr_pending_after", int'(bus.freq_pending), 0);
      collect(60);
      check("clr_s49", qget(49), 49);
      check("clr_s50", qget(50), 0);
      check("clr_s51", qget(51), 2);
      check("clr_s52", qget(52), 4);

      // ---- reset mid-operation, between clock edges ----
      bus.freq_we = 1'b1;
      bus.freq_in = F16;
      tick();
      bus.freq_we = 1'b0;
      check("midrst_pending_before", int'(bus.freq_pending), 1);
      #2;
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      #1;
      check("midrst_wave_out", int'(bus.wave_out), 128);
      check("midrst_sample_valid", int'(bus.sample_valid), 0);
      check("midrst_cycle_wrap", int'(bus.cycle_wrap), 0);
      check("midrst_freq_pending", int'(bus.freq_pending), 0);
      @(negedge clk_in);
      rst_n = 1'b1;

      // ---- fword = 0: constant output, pending only via phase_clr ----
      restart(2, '0, '0);
      collect(100);
      nz = 0;
      nw = 0;
      foreach (samp_q[i]) if (samp_q[i] != 0) nz++;
      foreach (wrap_q[i]) if (wrap_q[i] != 0) nw++;
      check("zero_word_constant", nz, 0);
      check("zero_word_no_wrap", nw, 0);
      bus.freq_we = 1'b1;
      bus.freq_in = F16;
      tick();
      bus.freq_we = 1'b0;
      repeat (50) tick();
      check("zero_word_pending_stays", int'(bus.freq_pending), 1);
      bus.phase_clr = 1'b1;
      tick();
      bus.phase_clr = 1'b0;
      check("zero_word_clr_applies", int'(bus.freq_pending), 0);
      samp_q.delete();
      wrap_q.delete();
      collect(5);
      check("zero_word_after_clr_s3", qget(3), 1);
      check("zero_word_after_clr_s4", qget(4), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
